// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, counter widths and common keyboard commands.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    FAIL
  } ps2_tx_state_e;

  localparam int CNT_W = 21;
  localparam int BI_W  = 4;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes and run-length filters one PS/2 line; fall strobes one cycle as the filtered value drops.
// Latency: 2 sync flops plus FILTER_LEN samples; no backpressure.
module ps2_line_filter #(
  parameter int FILTER_LEN = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_f,
  output logic fall
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [FW-1:0] run_q, run_d;

  always_comb begin
    sync_d = {sync_q[0], line_i};
    filt_d = filt_q;
    run_d  = '0;
    // Output flips only on the FILTER_LEN-th consecutive sample that disagrees with it.
    if (sync_q[1] != filt_q) begin
      if (run_q == FW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else                              run_d  = run_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      run_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      run_q  <= run_d;
    end
  end

  assign line_f = filt_q;
  assign fall   = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 8 data bits LSB-first, odd parity, stop, ACK check.
// Accepts one byte only in IDLE (tx_ready); frame latency is set by the device clock; done/error pulse at the end.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       kb_clk_i,
  input  logic       kb_data_i,
  output logic       kb_clk_oe,
  output logic       kb_data_oe
);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [BI_W-1:0]  bi_q, bi_d;
  logic [8:0]       sr_q, sr_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;

  logic kb_clk_f, kb_data_f, clk_fall, data_fall_unused;
  logic timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (kb_clk_i),
    .line_f (kb_clk_f),
    .fall   (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (kb_data_i),
    .line_f (kb_data_f),
    .fall   (data_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    bi_d      = bi_q;
    sr_d      = sr_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    timeout   = (to_q >= TO_LAST);

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          sr_d      = {odd_parity(tx_data), tx_data};
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RELEASE: begin
        clk_oe_d = 1'b0;
        to_d     = '0;
        bi_d     = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        to_d = sat_inc(to_q);
        if (timeout) begin
          state_d = FAIL;
        end else if (clk_fall) begin
          if (bi_q <= 4'd8) begin
            data_oe_d = ~sr_q[bi_q];
            bi_d      = bi_q + 1'b1;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        to_d = sat_inc(to_q);
        if (timeout)       state_d = FAIL;
        else if (clk_fall) state_d = kb_data_f ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        to_d = sat_inc(to_q);
        if (timeout)                   state_d = FAIL;
        else if (kb_clk_f && kb_data_f) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Lines are already released during the error cycle itself.
    if (state_d == FAIL) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      bi_q      <= '0;
      sr_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      bi_q      <= bi_d;
      sr_q      <= sr_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == FAIL);
  assign kb_clk_oe  = clk_oe_q;
  assign kb_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model on the open-drain lines.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TO  = 2500;
  localparam int FL  = 4;

  typedef struct {
    logic [7:0] data;
    int         mode;   // 0 = device ACKs, 1 = device leaves data high at ACK, 2 = device never clocks
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       kb_clk_i, kb_data_i, kb_clk_oe, kb_data_oe;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low = 1'b0;

  assign kb_clk_i  = ~(kb_clk_oe | dev_clk_low | glitch_low);
  assign kb_data_i = ~(kb_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .kb_clk_i   (kb_clk_i),
    .kb_data_i  (kb_data_i),
    .kb_clk_oe  (kb_clk_oe),
    .kb_data_oe (kb_data_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_exp_done = 0;
  exp_t sbq[$];
  logic [10:0] cap;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Frame as seen on the wire: start 0, data LSB first, parity makes total ones odd, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic device(input int mode, input int half, input bit glitch, input int stop_after);
    int w;
    cap = '1;
    w = 0;
    while (!(kb_clk_i && !kb_data_i) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("rts_seen", (kb_clk_i && !kb_data_i), 1);
    if (mode == 2) return;
    cycles(half);
    cap[0] = kb_data_i;
    for (int k = 1; k <= 11; k++) begin
      if (k > stop_after) return;
      dev_clk_low = 1'b1;
      cycles(half);
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k] = kb_data_i;
      if (k == 10 && mode == 0) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      if (glitch && k == 5) begin
        cycles(10);
        glitch_low = 1'b1;
        cycles(FL - 1);
        glitch_low = 1'b0;
        cycles(half - 10 - (FL - 1));
      end else begin
        cycles(half);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input int mode, input int half, input bit glitch,
                      input int stop_after, input bit push);
    int w;
    exp_t e;
    cycles(1);
    w = 0;
    while (!tx_ready && w < 100) begin
      cycles(1);
      w++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (push) begin
      e.data = d;
      e.mode = mode;
      sbq.push_back(e);
      if (mode == 0) n_exp_done++;
    end
    cycles(1);
    tx_valid = 1'b0;
    // Requests while busy must be ignored.
    cycles(3);
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    cycles(4);
    tx_valid = 1'b0;
    device(mode, half, glitch, stop_after);
  endtask

  task automatic wait_end(input int bound);
    int w;
    w = 0;
    while (sbq.size() != 0 && w < bound) begin
      cycles(1);
      w++;
    end
    chk("frame_completed", sbq.size(), 0);
    sbq.delete();
    cycles(3);
  endtask

  // Monitor: frame bookkeeping plus scoreboard pop on every done/error pulse.
  initial begin
    int cyc, inh_cnt, ready_viol, rel_cyc;
    bit in_frame, post_pend, clk_oe_prev;
    exp_t e;
    cyc = 0; inh_cnt = 0; ready_viol = 0; rel_cyc = 0;
    in_frame = 0; post_pend = 0; clk_oe_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 0;
        post_pend = 0;
        clk_oe_prev = 0;
        continue;
      end
      if (post_pend) begin
        post_pend = 0;
        chk("idle_after_end", {tx_ready, busy, done, error}, 4'b1000);
      end
      if (kb_clk_oe) inh_cnt++;
      if (clk_oe_prev && !kb_clk_oe) rel_cyc = cyc;
      clk_oe_prev = kb_clk_oe;
      if (in_frame && tx_ready) ready_viol++;
      if (tx_valid && tx_ready) begin
        in_frame = 1;
        inh_cnt = 0;
        ready_viol = 0;
      end
      if (done || error) begin
        in_frame = 0;
        post_pend = 1;
        if (done) n_done++;
        chk("sb_has_entry", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("done_vs_expected", done, (e.mode == 0));
          chk("error_vs_expected", error, (e.mode != 0));
          chk("inhibit_len", inh_cnt, INH + 1);
          chk("ready_low_in_frame", ready_viol, 0);
          if (e.mode != 2) chk("frame_bits", cap, model_frame(e.data));
          if (error) chk("lines_released", {kb_clk_oe, kb_data_oe}, 0);
          if (e.mode == 2) chk("timeout_cycles", cyc - rel_cyc, TO);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    cycles(3);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {done, error}, 0);
    chk("reset_oe", {kb_clk_oe, kb_data_oe}, 0);
    rst_n = 1'b1;
    cycles(FL + 5);

    send(8'hED, 0, 40, 0, 99, 1);
    wait_end(4000);
    send(8'h01, 0, 40, 0, 99, 1);
    wait_end(4000);
    send(8'hFF, 0, 40, 0, 99, 1);
    wait_end(4000);
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 0, int'($urandom_range(50, 30)), 0, 99, 1);
      wait_end(4000);
    end

    send(8'($urandom), 1, 40, 0, 99, 1);
    wait_end(4000);
    send(8'($urandom), 2, 40, 0, 99, 1);
    wait_end(TO + 500);
    send(8'($urandom), 0, 40, 1, 99, 1);
    wait_end(4000);

    // Reset in the middle of SHIFT, right after bit index reached 4 with D3 = 0 on the line.
    d = 8'($urandom);
    d[3] = 1'b0;
    send(d, 0, 40, 0, 4, 0);
    chk("d3_driven_low", {kb_clk_oe, kb_data_oe}, 2'b01);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_release", {kb_clk_oe, kb_data_oe}, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(FL + 5);
    chk("ready_after_reset", {tx_ready, busy}, 2'b10);

    send(8'hEE, 0, 40, 0, 99, 1);
    wait_end(4000);

    chk("done_count", n_done, n_exp_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset.
- Sits beside the keyboard receiver on the same kb_clk/kb_data pair and drives both lines open-drain.
- Runs the full request-to-send sequence, shifts out data LSB-first plus odd parity and stop, then checks the device ACK.
- Exports busy so the receiver path can ignore line activity during a host transfer.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles kb_clk is held low to inhibit the device (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles from clock release to ACK complete (15 ms); exceeding it is an error.
- FILTER_LEN, 20: consecutive identical samples needed before a filtered line value changes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid & tx_ready in the same cycle
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: frame acknowledged by device
- error  out  1  one-cycle pulse: missing ACK or timeout
- kb_clk_i  in  1  sampled PS/2 clock line
- kb_data_i  in  1  sampled PS/2 data line
- kb_clk_oe  out  1  1 = pull kb_clk low; 0 = release
- kb_data_oe  out  1  1 = pull kb_data low; 0 = release

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; tx_ready=1; busy=0; done=0; error=0; kb_clk_oe=0; kb_data_oe=0.
  - Filter outputs are 1; all counters are 0.
  - Reset asserted mid-frame releases both lines immediately, with no clock edge needed.
- Input conditioning: 2-flop synchronizer per line, then a FILTER_LEN-sample filter. A falling edge of filtered kb_clk (fall) is a one-cycle strobe.
- Accept: tx_valid & tx_ready in IDLE latches tx_data into shift register sr[8:0] = {odd parity, tx_data}.
  - odd parity = ~^tx_data.
  - tx_valid while busy is ignored.
- States:
  - IDLE:
    - On accept: kb_clk_oe=1, cnt=0, go to INHIBIT.
  - INHIBIT:
    - cnt counts up.
    - At cnt==INHIBIT_CYCLES-1: kb_data_oe=1 (start bit 0), go to RELEASE.
  - RELEASE:
    - After 1 cycle, kb_clk_oe=0. Clear the timeout counter and bit index bi=0, go to SHIFT.
  - SHIFT:
    - On each fall with bi<=8: kb_data_oe = ~sr[bi], bi++. Bit order is D0..D7, then parity.
    - On the fall with bi==9: kb_data_oe=0 (stop bit 1), go to ACK.
  - ACK:
    - On the next fall, sample filtered kb_data. 0 goes to WAIT_IDLE; 1 goes to FAIL.
  - WAIT_IDLE:
    - When filtered kb_clk and kb_data are both 1, go to DONE.
  - DONE:
    - done=1 for one cycle, then IDLE.
  - FAIL:
    - Force kb_clk_oe=0 and kb_data_oe=0; error=1 for one cycle; then IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES goes to FAIL from any of them. This takes priority over a fall in the same cycle.
- The INHIBIT length is exact: kb_clk_oe is high for INHIBIT_CYCLES+1 cycles (INHIBIT plus RELEASE).
- A new accept is possible the cycle after done or error.
- Widths:
  - cnt and the timeout counter are 21 bits and saturate. The design must not rely on wrap-around.
  - bi is 4 bits.

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE, DONE, FAIL.
  - Command constants: CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF.
- One sub-module: ps2_line_filter (synchronizer + FILTER_LEN filter + fall strobe). The keyboard receiver path can reuse it.

Test Plan:
- Send 0xED; the device model clocks at 12.5 kHz and ACKs with data=0.
  - Required: kb_clk_oe high exactly INHIBIT_CYCLES+1 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released.
  - done pulses once; busy falls with done.
- Send 0x01, then 0xFF.
  - Required: parity bits 0 and 1 respectively; both get done; tx_ready=0 throughout each frame.
- Device model holds data=1 at the ACK clock.
  - Required: error pulse; both oe=0; state IDLE; done never asserted.
- Device model never clocks after release.
  - Required: error exactly TIMEOUT_CYCLES cycles after RELEASE exits; lines released.
- rst_n dropped during SHIFT at bit 4.
  - Required: kb_clk_oe=kb_data_oe=0 asynchronously; tx_ready=1 after release; the next 0xEE frame completes with done.
- Glitch on kb_clk_i shorter than FILTER_LEN cycles during SHIFT.
  - Required: no fall; bit index unchanged; frame still correct.
